irq_ctrl: RTL and testbench
===========================

Name: irq_ctrl

Overview:
- Interrupt controller that receives level-sensitive interrupt lines (timer tim_int and peer peripherals) and presents one interrupt request to the CPU.
- Per-source pending/in-service tracking, fixed priority (lowest index wins), claim/complete handshake with software.
- A source's own status bit (e.g. timer int_st, write-1-to-clear) stays the source of truth; this block gates re-signalling until software completes service.

Parameters:
NUM_SRC, 8, number of interrupt sources (2..32)
ID_W, 3, width of source ID; must satisfy 2**ID_W >= NUM_SRC

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
irq_src  input  NUM_SRC  level interrupt lines, synchronous to clk
irq_en  input  NUM_SRC  per-source enable (mask) from config register
claim_req  input  1  one-cycle claim strobe from CPU bus
claim_valid  output  1  one-cycle pulse answering claim_req
claim_hit  output  1  qualifies claim_valid: 1 = a source was claimed
claim_id  output  ID_W  claimed source index (0 when claim_hit=0)
complete_req  input  1  one-cycle completion strobe
complete_id  input  ID_W  ID being completed
complete_err  output  1  one-cycle pulse: completion rejected
cpu_irq  output  1  interrupt request to CPU, registered
pending  output  NUM_SRC  pending bits (status readback)
in_service  output  1  a claimed source awaits completion
active_id  output  ID_W  ID of the in-service source

Behaviour:
- Reset: all outputs 0, pending=0, busy=0, state=IDLE.
- Pending set: at each edge, pending[i] <= 1 if irq_src[i] & irq_en[i] & ~busy[i]. Pending is cleared only by a claim of i. Clearing irq_en[i] does not clear pending[i]; it masks pending[i] from arbitration and cpu_irq.
- eligible = pending & irq_en. The winner is the lowest set index of eligible.
- State IDLE:
  - eligible != 0 at an edge -> PEND.
  - claim_req -> claim_valid=1, claim_hit=0, claim_id=0.
- State PEND: cpu_irq=1, registered, i.e. cpu_irq == (state==PEND).
  - claim_req with eligible != 0 -> claim_valid=1, claim_hit=1, claim_id=winner, pending[winner]<=0, busy[winner]<=1, active_id<=winner, state -> SERVICE, all on the same edge.
  - claim_req with eligible == 0 -> hit=0, state -> IDLE.
  - eligible becomes 0 without a claim -> IDLE.
- State SERVICE: cpu_irq=0 (no nesting), in_service=1.
  - claim_req -> claim_valid=1, claim_hit=0.
  - complete_req with complete_id==active_id -> busy[active_id]<=0, state -> IDLE.
- complete_req in any other case (wrong ID, or not in SERVICE) -> complete_err pulse next cycle, no state change.
- Latency:
  - irq_src high before edge E0 -> pending after E0 -> cpu_irq high after E1.
  - claim_req sampled at edge E -> claim_valid/claim_hit/claim_id valid for exactly one cycle after E.
  - cpu_irq falls after the claim edge E.
- Simultaneous events:
  - A source rising in the same cycle as claim_req does not take part in that arbitration; it pends on that edge and competes afterwards.
  - claim_req and complete_req in the same SERVICE cycle: the complete is processed and the claim returns hit=0.
  - A source still high after completion re-pends on the next edge. This is the correct behaviour when software has not yet cleared the peripheral's status bit.
- Reset asserted mid-service: everything returns to reset values asynchronously. Sources still high re-pend after reset release.

Test Plan:
1. Reset mid-SERVICE (src 3 claimed) -> all outputs 0 immediately; src 3 still high -> pending[3] after the first edge post-release, cpu_irq after the second.
2. irq_en=8'hFF; irq_src[5] asserted before edge E0 -> pending=8'h20 after E0, cpu_irq=1 after E1; claim_req -> claim_valid=1, claim_hit=1, claim_id=5, pending=0, in_service=1, cpu_irq=0.
3. irq_src=8'h0C simultaneously, claim -> id 2; complete_id=2 -> IDLE, then PEND, claim -> id 3, pending=0.
4. irq_en[1]=0, irq_src[1]=1 -> pending stays 0, cpu_irq=0; claim_req -> claim_valid=1, claim_hit=0, claim_id=0.
5. In SERVICE with active_id=4: complete_id=6 -> complete_err pulse, still SERVICE; claim_req -> claim_hit=0; complete_id=4 with irq_src[4] still high -> pending[4]=1 the next edge, cpu_irq again one cycle later.
6. irq_src[0] rises in the cycle of claim_req while src 7 is pending -> claim_id=7; pending[0] set on that edge; after complete(7), claim -> id 0.

Source files
------------

// File: rtl/irq_ctrl.sv
// Interrupt controller: level-sensitive sources, per-source pending/busy tracking,
// fixed priority (lowest index wins), and a claim/complete handshake with software.
module irq_ctrl #(
    parameter int unsigned NUM_SRC = 8,
    parameter int unsigned ID_W    = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic [NUM_SRC-1:0] irq_en,
    input  logic               claim_req,
    output logic               claim_valid,
    output logic               claim_hit,
    output logic [ID_W-1:0]    claim_id,
    input  logic               complete_req,
    input  logic [ID_W-1:0]    complete_id,
    output logic               complete_err,
    output logic               cpu_irq,
    output logic [NUM_SRC-1:0] pending,
    output logic               in_service,
    output logic [ID_W-1:0]    active_id
);

    typedef enum logic [1:0] {StIdle, StPend, StService} state_e;

    state_e             state;
    logic [NUM_SRC-1:0] busy;
    logic [NUM_SRC-1:0] eligible;
    logic [ID_W-1:0]    winner;
    logic [NUM_SRC-1:0] winner_mask;
    logic [NUM_SRC-1:0] active_mask;
    logic               do_claim;
    logic               do_complete;
    logic [NUM_SRC-1:0] pending_nxt;
    logic [NUM_SRC-1:0] busy_nxt;

    assign eligible    = pending & irq_en;
    assign winner_mask = NUM_SRC'(1) << winner;
    assign active_mask = NUM_SRC'(1) << active_id;
    assign do_claim    = (state == StPend) && claim_req && (eligible != '0);
    assign do_complete = complete_req && (state == StService) && (complete_id == active_id);

    // Both outputs are decoded straight from the state register, so they are glitch-free.
    assign cpu_irq    = (state == StPend);
    assign in_service = (state == StService);

    // Priority encoder: lowest set index of eligible wins.
    always_comb begin
        winner = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                winner = ID_W'(i);
            end
        end
    end

    // Next pending/busy: set from live sources (blocked while busy), claim clears the winner
    // after the set term so a winner whose line is still high does not re-pend on the claim edge.
    always_comb begin
        pending_nxt = (pending | (irq_src & irq_en & ~busy)) & ~(do_claim ? winner_mask : '0);
        busy_nxt    = (busy | (do_claim ? winner_mask : '0)) & ~(do_complete ? active_mask : '0);
    end

    // Pending/busy state, handshake response pulses and the claim/service FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= StIdle;
            pending      <= '0;
            busy         <= '0;
            active_id    <= '0;
            claim_valid  <= 1'b0;
            claim_hit    <= 1'b0;
            claim_id     <= '0;
            complete_err <= 1'b0;
        end else begin
            pending      <= pending_nxt;
            busy         <= busy_nxt;
            claim_valid  <= claim_req;
            claim_hit    <= 1'b0;
            claim_id     <= '0;
            complete_err <= complete_req && !do_complete;
            unique case (state)
                StIdle: begin
                    if (eligible != '0) begin
                        state <= StPend;
                    end
                end
                StPend: begin
                    if (do_claim) begin
                        claim_hit <= 1'b1;
                        claim_id  <= winner;
                        active_id <= winner;
                        state     <= StService;
                    end else if (eligible == '0) begin
                        state <= StIdle;
                    end
                end
                StService: begin
                    if (do_complete) begin
                        active_id <= '0;
                        state     <= StIdle;
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: hand-computed expectations checked with immediate assertions.
module tb_irq_ctrl;

    localparam int unsigned NUM_SRC = 8;
    localparam int unsigned ID_W    = 3;

    logic               clk;
    logic               rst_n;
    logic [NUM_SRC-1:0] irq_src;
    logic [NUM_SRC-1:0] irq_en;
    logic               claim_req;
    logic               claim_valid;
    logic               claim_hit;
    logic [ID_W-1:0]    claim_id;
    logic               complete_req;
    logic [ID_W-1:0]    complete_id;
    logic               complete_err;
    logic               cpu_irq;
    logic [NUM_SRC-1:0] pending;
    logic               in_service;
    logic [ID_W-1:0]    active_id;

    int checks = 0;
    int errors = 0;

    irq_ctrl #(
        .NUM_SRC(NUM_SRC),
        .ID_W   (ID_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .irq_src     (irq_src),
        .irq_en      (irq_en),
        .claim_req   (claim_req),
        .claim_valid (claim_valid),
        .claim_hit   (claim_hit),
        .claim_id    (claim_id),
        .complete_req(complete_req),
        .complete_id (complete_id),
        .complete_err(complete_err),
        .cpu_irq     (cpu_irq),
        .pending     (pending),
        .in_service  (in_service),
        .active_id   (active_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n        = 1'b0;
        irq_src      = '0;
        irq_en       = '0;
        claim_req    = 1'b0;
        complete_req = 1'b0;
        complete_id  = '0;
        step();
        step();
        chk("rst_cpu_irq", 32'(cpu_irq), 0);
        chk("rst_pending", 32'(pending), 0);
        chk("rst_claim_valid", 32'(claim_valid), 0);
        chk("rst_in_service", 32'(in_service), 0);
        chk("rst_active_id", 32'(active_id), 0);
        rst_n = 1'b1;

        // Single source 5: pend after E0, cpu_irq after E1, claim.
        irq_en  = 8'hFF;
        irq_src = 8'h20;
        step();
        chk("t2_pending_e0", 32'(pending), 32'h20);
        chk("t2_cpu_irq_e0", 32'(cpu_irq), 0);
        step();
        chk("t2_cpu_irq_e1", 32'(cpu_irq), 1);
        claim_req = 1'b1;
        step();
        chk("t2_claim_valid", 32'(claim_valid), 1);
        chk("t2_claim_hit", 32'(claim_hit), 1);
        chk("t2_claim_id", 32'(claim_id), 5);
        chk("t2_pending", 32'(pending), 0);
        chk("t2_in_service", 32'(in_service), 1);
        chk("t2_cpu_irq", 32'(cpu_irq), 0);
        chk("t2_active_id", 32'(active_id), 5);
        claim_req = 1'b0;
        irq_src   = '0;
        step();
        chk("t2_claim_valid_pulse", 32'(claim_valid), 0);
        complete_req = 1'b1;
        complete_id  = 3'd5;
        step();
        chk("t2_done_in_service", 32'(in_service), 0);
        chk("t2_done_err", 32'(complete_err), 0);
        complete_req = 1'b0;
        step();

        // Sources 2 and 3 together: priority order 2 then 3.
        irq_src = 8'h0C;
        step();
        chk("t3_pending", 32'(pending), 32'h0C);
        step();
        chk("t3_cpu_irq", 32'(cpu_irq), 1);
        claim_req = 1'b1;
        step();
        chk("t3_claim_id_a", 32'(claim_id), 2);
        chk("t3_pending_a", 32'(pending), 32'h08);
        claim_req    = 1'b0;
        irq_src      = '0;
        complete_req = 1'b1;
        complete_id  = 3'd2;
        step();
        chk("t3_idle", 32'(in_service), 0);
        complete_req = 1'b0;
        step();
        chk("t3_cpu_irq_b", 32'(cpu_irq), 1);
        claim_req = 1'b1;
        step();
        chk("t3_claim_id_b", 32'(claim_id), 3);
        chk("t3_pending_b", 32'(pending), 0);
        claim_req    = 1'b0;
        complete_req = 1'b1;
        complete_id  = 3'd3;
        step();
        complete_req = 1'b0;
        step();

        // Masked source never pends; claim in IDLE misses; complete in IDLE errors.
        irq_en  = 8'hFD;
        irq_src = 8'h02;
        step();
        step();
        chk("t4_pending", 32'(pending), 0);
        chk("t4_cpu_irq", 32'(cpu_irq), 0);
        claim_req = 1'b1;
        step();
        chk("t4_claim_valid", 32'(claim_valid), 1);
        chk("t4_claim_hit", 32'(claim_hit), 0);
        chk("t4_claim_id", 32'(claim_id), 0);
        claim_req    = 1'b0;
        irq_src      = '0;
        irq_en       = 8'hFF;
        complete_req = 1'b1;
        complete_id  = 3'd0;
        step();
        chk("t4_idle_complete_err", 32'(complete_err), 1);
        complete_req = 1'b0;
        step();
        chk("t4_err_pulse", 32'(complete_err), 0);

        // Wrong-ID complete, claim while in service, re-pend of a still-high source.
        irq_src = 8'h10;
        step();
        step();
        chk("t5_cpu_irq", 32'(cpu_irq), 1);
        claim_req = 1'b1;
        step();
        chk("t5_claim_id", 32'(claim_id), 4);
        claim_req    = 1'b0;
        complete_req = 1'b1;
        complete_id  = 3'd6;
        step();
        chk("t5_wrong_err", 32'(complete_err), 1);
        chk("t5_still_service", 32'(in_service), 1);
        chk("t5_active_id", 32'(active_id), 4);
        complete_req = 1'b0;
        claim_req    = 1'b1;
        step();
        chk("t5_err_cleared", 32'(complete_err), 0);
        chk("t5_claim_valid", 32'(claim_valid), 1);
        chk("t5_claim_hit", 32'(claim_hit), 0);
        chk("t5_no_pend_while_busy", 32'(pending), 0);
        claim_req    = 1'b0;
        complete_req = 1'b1;
        complete_id  = 3'd4;
        step();
        chk("t5_complete_idle", 32'(in_service), 0);
        chk("t5_complete_pending", 32'(pending), 0);
        complete_req = 1'b0;
        step();
        chk("t5_repend", 32'(pending), 32'h10);
        chk("t5_repend_cpu_irq", 32'(cpu_irq), 0);
        step();
        chk("t5_repend_cpu_irq_b", 32'(cpu_irq), 1);
        claim_req = 1'b1;
        step();
        chk("t5_reclaim_id", 32'(claim_id), 4);
        claim_req    = 1'b0;
        irq_src      = '0;
        complete_req = 1'b1;
        complete_id  = 3'd4;
        step();
        complete_req = 1'b0;
        step();

        // Source 0 rising on the claim edge does not beat pending source 7.
        irq_src = 8'h80;
        step();
        step();
        chk("t6_cpu_irq", 32'(cpu_irq), 1);
        irq_src   = 8'h81;
        claim_req = 1'b1;
        step();
        chk("t6_claim_id", 32'(claim_id), 7);
        chk("t6_pending", 32'(pending), 32'h01);
        claim_req    = 1'b0;
        irq_src      = '0;
        complete_req = 1'b1;
        complete_id  = 3'd7;
        step();
        chk("t6_complete", 32'(in_service), 0);
        complete_req = 1'b0;
        step();
        chk("t6_cpu_irq_b", 32'(cpu_irq), 1);
        claim_req = 1'b1;
        step();
        chk("t6_claim_hit_b", 32'(claim_hit), 1);
        chk("t6_claim_id_b", 32'(claim_id), 0);
        claim_req    = 1'b0;
        complete_req = 1'b1;
        complete_id  = 3'd0;
        step();
        complete_req = 1'b0;
        step();

        // Asynchronous reset in the middle of servicing source 3.
        irq_src = 8'h08;
        step();
        step();
        claim_req = 1'b1;
        step();
        chk("t1_claim_id", 32'(claim_id), 3);
        chk("t1_in_service", 32'(in_service), 1);
        claim_req = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t1_rst_in_service", 32'(in_service), 0);
        chk("t1_rst_active_id", 32'(active_id), 0);
        chk("t1_rst_claim_valid", 32'(claim_valid), 0);
        chk("t1_rst_claim_id", 32'(claim_id), 0);
        chk("t1_rst_cpu_irq", 32'(cpu_irq), 0);
        chk("t1_rst_pending", 32'(pending), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("t1_repend", 32'(pending), 32'h08);
        chk("t1_repend_cpu_irq", 32'(cpu_irq), 0);
        step();
        chk("t1_cpu_irq", 32'(cpu_irq), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
